// File: rtl/apb_sanity_bist.sv
// rtl/apb_sanity_bist.sv - APB master running a self-checking write-then-read sanity sequence
// Writes seed+i to BASE_ADDR+i*ADDR_STRIDE, reads back with index wrap, counts errors.
module apb_sanity_bist #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int CNT_WIDTH   = 8,
   parameter int BASE_ADDR   = 0,
   parameter int ADDR_STRIDE = 4,
   parameter int TIMEOUT     = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  wr_count,
   input  logic [CNT_WIDTH-1:0]  rd_count,
   input  logic [DATA_WIDTH-1:0] seed,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  timeout,
   output logic [CNT_WIDTH-1:0]  pkt_count,
   output logic [CNT_WIDTH-1:0]  err_count
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(ADDR_STRIDE);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

   logic [1:0]            state_q,   state_d;
   logic [CNT_WIDTH-1:0]  wr_cnt_q,  wr_cnt_d;
   logic [CNT_WIDTH-1:0]  rd_cnt_q,  rd_cnt_d;
   logic [DATA_WIDTH-1:0] seed_q,    seed_d;
   logic [CNT_WIDTH-1:0]  idx_q,     idx_d;
   logic [CNT_WIDTH-1:0]  rd_num_q,  rd_num_d;
   logic                  phase_rd_q, phase_rd_d;
   logic [WAIT_W-1:0]     wait_q,    wait_d;
   logic                  psel_q,    psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q,  pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q,   paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
   logic                  busy_q,    busy_d;
   logic                  done_q,    done_d;
   logic                  pass_q,    pass_d;
   logic                  timeout_q, timeout_d;
   logic [CNT_WIDTH-1:0]  pkt_q,     pkt_d;
   logic [CNT_WIDTH-1:0]  err_q,     err_d;

   logic [CNT_WIDTH-1:0]  nxt_idx;
   logic                  nxt_rd;
   logic                  last_xfer;
   logic                  rd_bad;
   logic [CNT_WIDTH-1:0]  wr_last;
   logic [CNT_WIDTH-1:0]  rd_last;

   function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [CNT_WIDTH-1:0] i);
      return BASE_A + STRIDE_A * ADDR_WIDTH'(i);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] data_of(input logic [DATA_WIDTH-1:0] s,
                                                     input logic [CNT_WIDTH-1:0]  i);
      return s + DATA_WIDTH'(i);
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (c == '1) ? c : c + CNT_ONE;
   endfunction

   assign wr_last = wr_cnt_q - CNT_ONE;
   assign rd_last = rd_cnt_q - CNT_ONE;

   always_comb begin
      state_d    = state_q;
      wr_cnt_d   = wr_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      seed_d     = seed_q;
      idx_d      = idx_q;
      rd_num_d   = rd_num_q;
      phase_rd_d = phase_rd_q;
      wait_d     = wait_q;
      psel_d     = psel_q;
      penable_d  = penable_q;
      pwrite_d   = pwrite_q;
      paddr_d    = paddr_q;
      pwdata_d   = pwdata_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      pass_d     = pass_q;
      timeout_d  = timeout_q;
      pkt_d      = pkt_q;
      err_d      = err_q;
      nxt_idx    = '0;
      nxt_rd     = 1'b0;
      last_xfer  = 1'b0;
      rd_bad     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               wr_cnt_d   = wr_count;
               rd_cnt_d   = rd_count;
               seed_d     = seed;
               pkt_d      = '0;
               err_d      = '0;
               pass_d     = 1'b0;
               timeout_d  = 1'b0;
               busy_d     = 1'b1;
               idx_d      = '0;
               rd_num_d   = '0;
               wait_d     = '0;
               if (wr_count == '0 && rd_count == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d    = S_SETUP;
                  phase_rd_d = (wr_count == '0);
                  psel_d     = 1'b1;
                  penable_d  = 1'b0;
                  pwrite_d   = (wr_count != '0);
                  paddr_d    = addr_of('0);
                  if (wr_count != '0) pwdata_d = seed;
               end
            end
         end
         S_SETUP: begin
            state_d   = S_ACCESS;
            penable_d = 1'b1;
            wait_d    = '0;
         end
         S_ACCESS: begin
            if (PREADY) begin
               pkt_d  = sat_inc(pkt_q);
               // Reads are only checked when this run wrote the locations first.
               rd_bad = phase_rd_q && (wr_cnt_q != '0) && (PRDATA != data_of(seed_q, idx_q));
               if (PSLVERR || rd_bad) err_d = sat_inc(err_q);
               if (!phase_rd_q && idx_q != wr_last) begin
                  nxt_idx = idx_q + CNT_ONE;
               end else if (!phase_rd_q) begin
                  nxt_rd    = 1'b1;
                  last_xfer = (rd_cnt_q == '0);
                  rd_num_d  = '0;
               end else begin
                  nxt_rd    = 1'b1;
                  last_xfer = (rd_num_q == rd_last);
                  rd_num_d  = rd_num_q + CNT_ONE;
                  nxt_idx   = (wr_cnt_q == '0 || idx_q == wr_last) ? '0 : idx_q + CNT_ONE;
               end
               if (last_xfer) begin
                  state_d   = S_DONE;
                  psel_d    = 1'b0;
                  penable_d = 1'b0;
               end else begin
                  state_d    = S_SETUP;
                  penable_d  = 1'b0;
                  idx_d      = nxt_idx;
                  phase_rd_d = nxt_rd;
                  paddr_d    = addr_of(nxt_idx);
                  pwrite_d   = !nxt_rd;
                  if (!nxt_rd) pwdata_d = data_of(seed_q, nxt_idx);
               end
            end else if (wait_q == WAIT_W'(TIMEOUT)) begin
               timeout_d = 1'b1;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               state_d   = S_DONE;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_q == '0) && !timeout_q;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q    <= S_IDLE;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         seed_q     <= '0;
         idx_q      <= '0;
         rd_num_q   <= '0;
         phase_rd_q <= 1'b0;
         wait_q     <= '0;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         paddr_q    <= '0;
         pwdata_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         timeout_q  <= 1'b0;
         pkt_q      <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         seed_q     <= seed_d;
         idx_q      <= idx_d;
         rd_num_q   <= rd_num_d;
         phase_rd_q <= phase_rd_d;
         wait_q     <= wait_d;
         psel_q     <= psel_d;
         penable_q  <= penable_d;
         pwrite_q   <= pwrite_d;
         paddr_q    <= paddr_d;
         pwdata_q   <= pwdata_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         timeout_q  <= timeout_d;
         pkt_q      <= pkt_d;
         err_q      <= err_d;
      end
   end

   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign timeout   = timeout_q;
   assign pkt_count = pkt_q;
   assign err_count = err_q;

endmodule

// File: doc/apb_sanity_bist.md
# apb_sanity_bist

Synthesisable APB master that runs a self-checking write-then-read sanity sequence against an APB slave. On `start` it issues a programmable number of writes, each with a deterministic data pattern, then reads the locations back and compares each read against the expected pattern. It reports packet count, error count, timeout and pass/fail. It sits between a control/CSR block and any APB slave, and is the parametrised, in-silicon successor to the simulation-only sanity sequence: configurable widths, counts, stride and wait-state timeout, with built-in checking.

## Interface
- ADDR_WIDTH, 8, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width
- CNT_WIDTH, 8, width of wr_count/rd_count/pkt_count/err_count
- BASE_ADDR, 0, address of transfer index 0
- ADDR_STRIDE, 4, address increment per index
- TIMEOUT, 16, max consecutive ACCESS cycles with PREADY=0 (≥1)
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request, sampled only in IDLE
- wr_count  in  CNT_WIDTH  number of writes, latched on start
- rd_count  in  CNT_WIDTH  number of reads, latched on start
- seed  in  DATA_WIDTH  pattern base, latched on start
- PSEL, PENABLE, PWRITE  out  1  APB controls
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY, PSLVERR  in  1  APB slave response
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  result of last sequence, held
- timeout  out  1  last sequence aborted on PREADY timeout, held
- pkt_count  out  CNT_WIDTH  completed transfers (writes + reads, saturating)
- err_count  out  CNT_WIDTH  mismatches + PSLVERR responses (saturating)

## Operation
- FSM states are IDLE, SETUP, ACCESS and DONE.
- IDLE:
  - On start=1, latch counts and seed.
  - Clear pkt_count, err_count, pass and timeout.
  - Set busy.
  - If wr_count+rd_count==0, go to DONE; otherwise go to SETUP with phase=WRITE (or READ if wr_count==0).
- SETUP:
  - PSEL=1, PENABLE=0.
  - PADDR, PWRITE and PWDATA are driven from the current index.
  - Go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; all address/data/control are held stable.
  - On PREADY=1 the transfer completes and pkt_count increments.
  - If the next transfer exists, go directly to SETUP with no idle cycle; otherwise go to DONE.
- Write phase: index i = 0..wr_count-1; PADDR = BASE_ADDR + i*ADDR_STRIDE, truncated to ADDR_WIDTH; PWDATA = seed + i, modulo 2^DATA_WIDTH.
- Read phase:
  - rd_count reads; PWRITE=0, PWDATA holds its last value.
  - The read index restarts at 0 and wraps to 0 after wr_count-1, so reads beyond wr_count re-read earlier locations.
  - On completion, PRDATA is compared with seed + index; a mismatch increments err_count.
  - If wr_count==0, the reads start at index 0 and are not compared.
- PSLVERR=1 on a completing transfer increments err_count, both reads and writes. A read with both PSLVERR and a mismatch increments by 1 only.
- Timeout:
  - A wait counter runs in ACCESS while PREADY=0.
  - Reaching TIMEOUT sets timeout=1, deasserts PSEL/PENABLE in the next cycle, and goes to DONE. The aborted transfer is not counted.
- DONE: done=1 for one cycle; pass = (err_count==0 && !timeout); busy=0; go to IDLE.
- Start while busy is ignored.
- pkt_count and err_count saturate at all-ones.

## Timing
- Reset (async, PRESETn=0): every output is 0 immediately, including PSEL, PENABLE, PADDR, PWDATA, busy, done, pass, timeout and both counts. FSM goes to IDLE. A reset mid-transfer aborts the sequence with no done pulse.
- Start accepted at edge N: busy=1 and PSEL=1 from N+1.
- Zero-wait-state transfer: 2 cycles. A sequence of W writes and R reads ends with done at edge 1 + 2(W+R), counted from the start edge, plus total wait states.
- pass/timeout/counts are valid at the done cycle and held until the next accepted start.
- Timeout: PSEL deasserts TIMEOUT+1 cycles after ACCESS entry; done follows 1 cycle later.

## Test plan
- **Zero-wait-state basic run.** Slave is a zero-wait 8-entry RAM; wr=2, rd=2, seed=0x100.
  - Writes: 0x100 @0x00, 0x101 @0x04; reads return the same.
  - done 9 cycles after start; pass=1, pkt_count=4, err_count=0.
- **Wait states.** Slave inserts 3 wait states per transfer; wr=1, rd=1.
  - PADDR/PWDATA stable through the waits.
  - done at start+11; pass=1.
- **Mismatch and PSLVERR.** Slave corrupts the second read and raises PSLVERR on the first write; wr=2, rd=2.
  - err_count=2, pass=0, pkt_count=4.
- **Read wrap.** wr=2, rd=5.
  - Read addresses are 0x00, 0x04, 0x00, 0x04, 0x00.
  - All compare correctly; pass=1.
- **Timeout.** PREADY stuck 0 with TIMEOUT=16.
  - timeout=1, pass=0, pkt_count=0; PSEL low at ACCESS+17.
- **Boundary cases.**
  - wr=rd=0 → done on the cycle after start, pass=1.
  - start pulsed mid-sequence → ignored.
  - PRESETn pulsed mid-ACCESS → all outputs 0, no done pulse.
